// File: rtl/pe_config_loader_pkg.sv
// Shared types for the PE configuration daisy-chain loader.
package pe_cfg_pkg;

    localparam int PE_INST_WIDTH = 64;
    localparam int PE_ID         = 2;
    localparam int PE_INST_WORD  = 32;
    localparam int PE_CHAIN_LEN  = 4;
    localparam int PE_CONF       = PE_INST_WIDTH + PE_ID + 4;

    typedef enum logic [1:0] {
        WRITE   = 2'b00,
        WSWITCH = 2'b01,
        RSWITCH = 2'b10,
        START   = 2'b11
    } cfg_op_e;

    // Field order matches the PE frame layout, MSB first.
    typedef struct packed {
        logic [PE_INST_WIDTH-1:0] inst;
        logic [PE_ID-1:0]         id;
        logic                     valid;
        logic                     w_switch;
        logic                     r_switch;
        logic                     start;
    } pe_cfg_frame_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } loader_state_e;

endpackage

// File: rtl/pe_config_loader_if.sv
// Host command port of the PE configuration loader (valid/ready).
interface pe_config_loader_if
    import pe_cfg_pkg::*;
#(
    parameter int ID         = PE_ID,
    parameter int INST_WIDTH = PE_INST_WIDTH
) ();

    logic                  cmd_valid;
    logic                  cmd_ready;
    cfg_op_e               cmd_op;
    logic [ID-1:0]         cmd_id;
    logic [INST_WIDTH-1:0] cmd_inst;

    modport master (output cmd_valid, cmd_op, cmd_id, cmd_inst, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_id, cmd_inst, output cmd_ready);

endinterface

// File: rtl/pe_config_loader.sv
// Head-of-chain transmitter: turns host commands into PE config frames and
// tracks per-PE imem fill plus chain drain after a START.
module pe_config_loader
    import pe_cfg_pkg::*;
#(
    parameter int INST_WIDTH = PE_INST_WIDTH,
    parameter int ID         = PE_ID,
    parameter int INST_WORD  = PE_INST_WORD,
    parameter int CHAIN_LEN  = PE_CHAIN_LEN,
    parameter int CONF       = INST_WIDTH + ID + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pe_config_loader_if.slave    cmd,
    input  logic                 err_clr,
    output logic [CONF-1:0]      pe_config_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err_overflow
);

    localparam int NUM_PE  = 2 ** ID;
    localparam int FILL_W  = $clog2(INST_WORD) + 1;
    localparam int DRAIN_W = $clog2(CHAIN_LEN + 1);

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [ID-1:0]         id;
        logic                  valid;
        logic                  w_switch;
        logic                  r_switch;
        logic                  start;
    } frame_t;

    loader_state_e     state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [FILL_W-1:0]  fill_q [NUM_PE];
    logic [FILL_W-1:0]  fill_d [NUM_PE];
    frame_t             frame_q, frame_d;
    logic               err_q, err_d;
    logic               accept;

    assign cmd.cmd_ready = (state_q == IDLE) && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        fill_d  = fill_q;
        frame_d = '0;
        err_d   = err_q;
        done    = 1'b0;

        // Clear first so a same-cycle overflow below wins over err_clr.
        if (err_clr) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (cmd.cmd_op)
                        WRITE: begin
                            if (fill_q[cmd.cmd_id] == FILL_W'(INST_WORD)) begin
                                err_d = 1'b1;
                            end else begin
                                frame_d.inst        = cmd.cmd_inst;
                                frame_d.id          = cmd.cmd_id;
                                frame_d.valid       = 1'b1;
                                fill_d[cmd.cmd_id]  = fill_q[cmd.cmd_id] + FILL_W'(1);
                            end
                        end
                        WSWITCH: begin
                            frame_d.w_switch = 1'b1;
                            for (int i = 0; i < NUM_PE; i++) begin
                                fill_d[i] = '0;
                            end
                        end
                        RSWITCH: begin
                            frame_d.r_switch = 1'b1;
                        end
                        START: begin
                            frame_d.start = 1'b1;
                            state_d       = DRAIN;
                            drain_d       = DRAIN_W'(CHAIN_LEN);
                        end
                        default: begin
                        end
                    endcase
                end
            end
            DRAIN: begin
                drain_d = drain_q - DRAIN_W'(1);
                if (drain_q == DRAIN_W'(1)) begin
                    done    = !rst;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
            frame_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_PE; i++) begin
                fill_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            frame_q <= frame_d;
            err_q   <= err_d;
            fill_q  <= fill_d;
        end
    end

    assign pe_config_out = frame_q;
    assign busy          = (frame_q != '0) || (state_q == DRAIN);
    assign err_overflow  = err_q;

endmodule
